passcode_entry: RTL and testbench
=================================

# passcode_entry

Keypad-style passcode entry and checker that produces `passcode_correct` for the alarm system-state FSM. Digits are dialled on switches and committed with an active-low push button; a full entry is compared against a stored code while the system is in `STATE_SET` or `STATE_TRIGGER`. In `STATE_IDLE` a full entry reprograms the stored code. Repeated wrong entries trigger a timed lockout.

## Interface

**Parameters**
- `DIGITS`, 4: digits per code.
- `DIGIT_W`, 4: bits per digit.
- `DEFAULT_CODE`, 16'h1234: stored code after reset; width is `DIGITS*DIGIT_W`.
- `DEBOUNCE_CYCLES`, 500000: cycles a button must stay stable before it is accepted (10 ms at 50 MHz).
- `MAX_FAILS`, 3: consecutive wrong entries before lockout.
- `LOCK_CYCLES`, 500000000: lockout length in cycles (10 s at 50 MHz).

**Ports**
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `sw`  in  `DIGIT_W`  digit value; sampled on the enter event.
- `btn_enter`  in  1  raw active-low push button; commits a digit.
- `btn_clear`  in  1  raw active-low push button; discards the partial entry.
- `system_state`  in  `fsm_state_t`  current alarm state.
- `passcode_correct`  out  1  registered one-cycle pulse on a matching entry.
- `digit_count`  out  `$clog2(DIGITS+1)`  digits entered so far.
- `entry_digits`  out  `DIGITS*DIGIT_W`  entry buffer, for the display.
- `fail_count`  out  `$clog2(MAX_FAILS+1)`  consecutive wrong entries.
- `lockout`  out  1  high while entries are ignored.

## Operation

**Button conditioning (per button)**
- Two-flop synchroniser feeds a stable-level debouncer.
- The debounced level changes only after the synchronised input holds a new value for `DEBOUNCE_CYCLES` consecutive cycles.
- A debounced 1→0 transition yields a one-cycle press event.
- Debounced level resets to 1 (released).

**Internal FSM: `S_ENTRY`, `S_CHECK`, `S_LOCKOUT`. Reset state is `S_ENTRY`.**
- **S_ENTRY, enter press with `digit_count < DIGITS`:**
  - Shift `sw` into the low digit of `entry_digits`; the first digit entered ends up most significant.
  - Increment `digit_count`.
  - If the count becomes `DIGITS`, go to `S_CHECK`.
- **S_CHECK (exactly one cycle):**
  - `STATE_SET` or `STATE_TRIGGER`:
    - On match: pulse `passcode_correct`, clear `fail_count`, go to `S_ENTRY`.
    - On mismatch: increment `fail_count`. If it reaches `MAX_FAILS`, go to `S_LOCKOUT`; otherwise go to `S_ENTRY`.
  - `STATE_IDLE`: load the stored code from `entry_digits`. No pulse, no fail change. Go to `S_ENTRY`.
  - `STATE_ALERT`: discard the entry. Go to `S_ENTRY`.
  - In all cases, clear `entry_digits` and `digit_count`.
- **S_LOCKOUT:**
  - `lockout` is 1; enter and clear presses are ignored.
  - The lock timer counts up to `LOCK_CYCLES-1`, then clears `fail_count` and the timer and returns to `S_ENTRY`.
- **Clear press in `S_ENTRY`:** zero `entry_digits` and `digit_count`.
- **`system_state` change** (detected against a registered copy):
  - In `S_ENTRY`, zero the buffer and count.
  - Entering `STATE_IDLE` also zeroes `fail_count`.
  - `S_LOCKOUT` continues unaffected.
- **`STATE_ALERT` in `S_ENTRY`:** the buffer is held at zero and presses are ignored.

## Timing

- **Reset values:** `passcode_correct`=0, `digit_count`=0, `entry_digits`=0, `fail_count`=0, `lockout`=0, stored code=`DEFAULT_CODE`, FSM=`S_ENTRY`.
- **Press latency:** a raw press that is clean from cycle 0 gives a press event `2+DEBOUNCE_CYCLES` cycles later, ±1 cycle.
- **Final-digit latency:** press event in cycle N (final digit) → `S_CHECK` in N+1 → `passcode_correct` high in N+2 only.
- **Lockout timing:** `lockout` rises in N+2 and stays high for exactly `LOCK_CYCLES` cycles.
- **Simultaneous events in one cycle, in priority order:**
  1. `system_state` change
  2. clear press
  3. enter press
- A lower-priority event that loses is dropped, not queued.
- `S_CHECK` uses the `system_state` value in that cycle. It is never aborted by a state change.
- `fail_count` saturates at `MAX_FAILS`.
- The lock timer is 32 bits.
- Reset mid-entry, mid-check or mid-lockout returns every register to its reset value immediately (asynchronous).

## Test plan

Bench settings: `DEBOUNCE_CYCLES`=4, `LOCK_CYCLES`=100.

1. `STATE_SET`, enter 1,2,3,4 → one-cycle `passcode_correct` two cycles after the 4th press event; `fail_count`=0; `digit_count` back to 0.
2. `STATE_TRIGGER`, enter 1,2,3,5 three times → `fail_count` goes 1,2,3; `lockout` is high for exactly 100 cycles.
   - Presses during lockout change nothing.
   - After lockout, `fail_count`=0.
3. `STATE_IDLE`, enter 9,8,7,6 → no pulse. Then in `STATE_SET`:
   - 1,2,3,4 fails (`fail_count`=1).
   - 9,8,7,6 pulses `passcode_correct`.
4. Enter 1,2, press clear, enter 1,2,3,4 → single pulse.
   - Clear and enter in the same cycle: count unchanged, then zeroed.
5. Bounce: raw `btn_enter` glitch of 3 cycles low → no press event. Hold 6 cycles low → exactly one digit captured.
6. Reset asserted mid-lockout and mid-entry → all outputs 0 in the same cycle; stored code reverts to 16'h1234.

Source files
------------

// File: rtl/passcode_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : passcode_entry (with alarm_pkg)                        |
// | Description : Keypad passcode entry, checking, reprogramming and     |
// |               timed lockout after repeated wrong entries.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+

package alarm_pkg;
  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALERT   = 2'd3
  } fsm_state_t;
endpackage

module passcode_entry
  import alarm_pkg::*;
#(
  parameter int                          DIGITS          = 4,
  parameter int                          DIGIT_W         = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE    = 16'h1234,
  parameter int                          DEBOUNCE_CYCLES = 500000,
  parameter int                          MAX_FAILS       = 3,
  parameter int                          LOCK_CYCLES     = 500000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DIGIT_W-1:0]                 sw,
  input  logic                               btn_enter,
  input  logic                               btn_clear,
  input  fsm_state_t                         system_state,
  output logic                               passcode_correct,
  output logic [$clog2(DIGITS+1)-1:0]        digit_count,
  output logic [DIGITS*DIGIT_W-1:0]          entry_digits,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count,
  output logic                               lockout
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  c_cnt_full  = CNT_W'(DIGITS);
  localparam logic [FAIL_W-1:0] c_fail_max  = FAIL_W'(MAX_FAILS);
  localparam logic [DB_W-1:0]   c_db_last   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]       c_lock_last = 32'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ENTRY   = 2'd0,
    S_CHECK   = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Button conditioning: bit 0 = enter, bit 1 = clear
  // ---------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {btn_clear, btn_enter};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    // Synchronise, then accept a new level only after it has held for the full debounce window
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_level <= 1'b1;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_btn_raw[gi];
        r_sync2 <= r_sync1;
        r_press <= 1'b0;
        if (r_sync2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_db_last) begin
          r_cnt   <= '0;
          r_level <= r_sync2;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[gi] = r_press;
  end

  logic w_enter_press;
  logic w_clear_press;

  assign w_enter_press = w_press[0];
  assign w_clear_press = w_press[1];

  // ---------------------------------------------------------------------
  // Entry / check / lockout control
  // ---------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CODE_W-1:0] r_entry;
  logic [CODE_W-1:0] w_entry_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [FAIL_W-1:0] r_fail;
  logic [FAIL_W-1:0] w_fail_nxt;
  logic [FAIL_W-1:0] w_fail_inc;
  logic              r_pulse;
  logic              w_pulse_nxt;
  logic [31:0]       r_timer;
  logic [31:0]       w_timer_nxt;
  fsm_state_t        r_sys_prev;
  logic              w_sys_change;

  assign w_sys_change = (system_state != r_sys_prev);
  assign w_fail_inc   = (r_fail >= c_fail_max) ? c_fail_max : r_fail + 1'b1;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ENTRY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers following the next-state logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry    <= '0;
      r_code     <= DEFAULT_CODE;
      r_count    <= '0;
      r_fail     <= '0;
      r_pulse    <= 1'b0;
      r_timer    <= '0;
      r_sys_prev <= STATE_IDLE;
    end else begin
      r_entry    <= w_entry_nxt;
      r_code     <= w_code_nxt;
      r_count    <= w_count_nxt;
      r_fail     <= w_fail_nxt;
      r_pulse    <= w_pulse_nxt;
      r_timer    <= w_timer_nxt;
      r_sys_prev <= system_state;
    end
  end

  // Next-state logic; event priority is state change, then clear, then enter
  always_comb begin
    w_state_nxt = r_state;
    w_entry_nxt = r_entry;
    w_code_nxt  = r_code;
    w_count_nxt = r_count;
    w_fail_nxt  = r_fail;
    w_pulse_nxt = 1'b0;
    w_timer_nxt = r_timer;

    case (r_state)
      S_ENTRY: begin
        if (w_sys_change) begin
          w_entry_nxt = '0;
          w_count_nxt = '0;
          if (system_state == STATE_IDLE) begin
            w_fail_nxt = '0;
          end
        end else if (system_state == STATE_ALERT) begin
          w_entry_nxt = '0;
          w_count_nxt = '0;
        end else if (w_clear_press) begin
          w_entry_nxt = '0;
          w_count_nxt = '0;
        end else if (w_enter_press && (r_count < c_cnt_full)) begin
          // First digit ends up most significant after DIGITS shifts
          w_entry_nxt = {r_entry[CODE_W-DIGIT_W-1:0], sw};
          w_count_nxt = r_count + 1'b1;
          if (w_count_nxt == c_cnt_full) begin
            w_state_nxt = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        w_entry_nxt = '0;
        w_count_nxt = '0;
        w_state_nxt = S_ENTRY;
        case (system_state)
          STATE_SET, STATE_TRIGGER: begin
            if (r_entry == r_code) begin
              w_pulse_nxt = 1'b1;
              w_fail_nxt  = '0;
            end else begin
              w_fail_nxt = w_fail_inc;
              if (w_fail_inc == c_fail_max) begin
                w_state_nxt = S_LOCKOUT;
              end
            end
          end
          STATE_IDLE: begin
            w_code_nxt = r_entry;
          end
          default: begin
          end
        endcase
      end

      S_LOCKOUT: begin
        if (r_timer == c_lock_last) begin
          w_timer_nxt = '0;
          w_fail_nxt  = '0;
          w_state_nxt = S_ENTRY;
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end

      default: begin
        w_state_nxt = S_ENTRY;
      end
    endcase
  end

  assign passcode_correct = r_pulse;
  assign digit_count      = r_count;
  assign entry_digits     = r_entry;
  assign fail_count       = r_fail;
  assign lockout          = (r_state == S_LOCKOUT);

endmodule

`default_nettype wire

// File: tb/tb_passcode_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_passcode_entry                                      |
// | Description : Scoreboard bench for passcode_entry (directed vectors) |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+

module tb_passcode_entry;
  import alarm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw;
  logic        btn_enter;
  logic        btn_clear;
  fsm_state_t  system_state;
  logic        passcode_correct;
  logic [2:0]  digit_count;
  logic [15:0] entry_digits;
  logic [1:0]  fail_count;
  logic        lockout;

  passcode_entry #(
    .DIGITS          (4),
    .DIGIT_W         (4),
    .DEFAULT_CODE    (16'h1234),
    .DEBOUNCE_CYCLES (4),
    .MAX_FAILS       (3),
    .LOCK_CYCLES     (100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sw               (sw),
    .btn_enter        (btn_enter),
    .btn_clear        (btn_clear),
    .system_state     (system_state),
    .passcode_correct (passcode_correct),
    .digit_count      (digit_count),
    .entry_digits     (entry_digits),
    .fail_count       (fail_count),
    .lockout          (lockout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    pulse;
    int    fail;
    bit    lock;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   mon_pending = 1'b0;
  exp_t mon_e;
  int   lock_run = 0;
  int   lock_len = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_result(input string name, input bit pulse, input int fail, input bit lock);
    exp_t e;
    e.name  = name;
    e.pulse = pulse;
    e.fail  = fail;
    e.lock  = lock;
    sb_q.push_back(e);
  endtask

  task automatic press_enter(input logic [3:0] d);
    @(negedge clk);
    sw        = d;
    btn_enter = 1'b0;
    repeat (6) @(negedge clk);
    btn_enter = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_clear();
    @(negedge clk);
    btn_clear = 1'b0;
    repeat (6) @(negedge clk);
    btn_clear = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_both(input logic [3:0] d);
    @(negedge clk);
    sw        = d;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (6) @(negedge clk);
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      press_enter(code[15-4*i -: 4]);
    end
  endtask

  task automatic set_state(input fsm_state_t s);
    @(negedge clk);
    system_state = s;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: a full entry shows digit_count==4 during the check cycle; the result follows one cycle later
  initial begin
    forever begin
      @(negedge clk);
      if (mon_pending) begin
        mon_pending = 1'b0;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_check: got a completed entry, expected none");
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, ".pulse"}, int'(passcode_correct), int'(mon_e.pulse));
          check({mon_e.name, ".fail"},  int'(fail_count),       mon_e.fail);
          check({mon_e.name, ".lock"},  int'(lockout),          int'(mon_e.lock));
          check({mon_e.name, ".count"}, int'(digit_count),      0);
        end
      end else if (passcode_correct) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stray_pulse: got passcode_correct=1, expected 0");
      end
      if (!rst && digit_count == 3'd4) mon_pending = 1'b1;
    end
  end

  // Length of the most recent lockout window
  initial begin
    forever begin
      @(negedge clk);
      if (lockout) begin
        lock_run++;
      end else begin
        if (lock_run != 0) lock_len = lock_run;
        lock_run = 0;
      end
    end
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst          = 1'b1;
    sw           = 4'd0;
    btn_enter    = 1'b1;
    btn_clear    = 1'b1;
    system_state = STATE_IDLE;
    repeat (3) @(negedge clk);
    check("reset.pulse",   int'(passcode_correct), 0);
    check("reset.count",   int'(digit_count),      0);
    check("reset.entry",   int'(entry_digits),     0);
    check("reset.fail",    int'(fail_count),       0);
    check("reset.lockout", int'(lockout),          0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: correct default code while armed
    set_state(STATE_SET);
    expect_result("t1_correct", 1'b1, 0, 1'b0);
    enter_code(16'h1234);

    // 2: three wrong entries while triggered -> lockout
    set_state(STATE_TRIGGER);
    expect_result("t2_wrong1", 1'b0, 1, 1'b0);
    enter_code(16'h1235);
    expect_result("t2_wrong2", 1'b0, 2, 1'b0);
    enter_code(16'h1235);
    expect_result("t2_wrong3", 1'b0, 3, 1'b1);
    enter_code(16'h1235);
    press_enter(4'd7);
    press_clear();
    press_enter(4'd7);
    check("t2.lock_count",   int'(digit_count),  0);
    check("t2.lock_entry",   int'(entry_digits), 0);
    check("t2.lock_still",   int'(lockout),      1);
    w = 0;
    while (lockout && w < 300) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("t2.lock_release", int'(lockout),    0);
    check("t2.lock_len",     lock_len,         100);
    check("t2.fail_after",   int'(fail_count), 0);

    // 3: reprogram in idle, then old code fails and new code passes
    set_state(STATE_IDLE);
    expect_result("t3_program", 1'b0, 0, 1'b0);
    enter_code(16'h9876);
    set_state(STATE_SET);
    expect_result("t3_old_code", 1'b0, 1, 1'b0);
    enter_code(16'h1234);
    expect_result("t3_new_code", 1'b1, 0, 1'b0);
    enter_code(16'h9876);

    // 6a: reset mid-entry clears everything at once
    press_enter(4'd1);
    press_enter(4'd2);
    check("t6a.count_pre", int'(digit_count),  2);
    check("t6a.entry_pre", int'(entry_digits), 16'h0012);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6a.count", int'(digit_count),  0);
    check("t6a.entry", int'(entry_digits), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 4: partial entry, clear, full entry (also proves the code reverted to 1234)
    press_enter(4'd1);
    press_enter(4'd2);
    check("t4.count_partial", int'(digit_count), 2);
    press_clear();
    check("t4.count_cleared", int'(digit_count),  0);
    check("t4.entry_cleared", int'(entry_digits), 0);
    expect_result("t4_after_clear", 1'b1, 0, 1'b0);
    enter_code(16'h1234);
    press_enter(4'd5);
    press_both(4'd6);
    check("t4.both_count", int'(digit_count),  0);
    check("t4.both_entry", int'(entry_digits), 0);

    // 5: a three-cycle glitch is rejected, a six-cycle press is accepted once
    @(negedge clk);
    sw        = 4'd6;
    btn_enter = 1'b0;
    repeat (3) @(negedge clk);
    btn_enter = 1'b1;
    repeat (12) @(negedge clk);
    check("t5.glitch_count", int'(digit_count), 0);
    press_enter(4'd6);
    check("t5.hold_count", int'(digit_count),  1);
    check("t5.hold_entry", int'(entry_digits), 16'h0006);
    press_clear();

    // 6b: reset mid-lockout
    set_state(STATE_TRIGGER);
    expect_result("t6b_wrong1", 1'b0, 1, 1'b0);
    enter_code(16'h4321);
    expect_result("t6b_wrong2", 1'b0, 2, 1'b0);
    enter_code(16'h4321);
    expect_result("t6b_wrong3", 1'b0, 3, 1'b1);
    enter_code(16'h4321);
    check("t6b.lock_pre", int'(lockout), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6b.lockout", int'(lockout),    0);
    check("t6b.fail",    int'(fail_count), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6b.lockout_after", int'(lockout), 0);
    expect_result("t6b_default_code", 1'b1, 0, 1'b0);
    enter_code(16'h1234);

    repeat (10) @(negedge clk);
    check("scoreboard.empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
